commit_buffer: RTL
==================

Name: commit_buffer

Overview:
- In-order retirement buffer for the out-of-order core; the receiving end of the execution-unit `Result` channel.
- Dispatch allocates a `commit_id` per instruction. Execution units deliver `Result` packets, out of order, over a `Message` receiver port.
- Entries retire strictly in allocation order: write-backs go downstream as `CommitInfo`, and a mispredicted branch raises a one-cycle pipeline flush with the corrected PC.

Parameters:
- DEPTH, 16, number of entries; power of two, 2..128.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- alloc_en  in  1  dispatch requests one entry this cycle.
- alloc_reject  out  1  allocation refused: buffer full or flush cycle.
- alloc_id  out  8  commit_id granted when alloc_en & !alloc_reject.
- result_en  in  1  `Message` receiver en: result valid.
- result_msg  in  $bits(Result)  `Message` receiver msg: Result packet.
- result_reject  out  1  `Message` receiver reject; sender drops the packet, no retry.
- commit_en  out  1  `Message` sender en: `CommitInfo` valid.
- commit_msg  out  $bits(CommitInfo)  dest_logic, data of the head write-back.
- commit_reject  in  1  downstream refuses the commit this cycle.
- flush  out  1  one-cycle pulse on retirement of a mispredicted branch.
- flush_pc  out  16  corrected PC; valid while flush=1.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- State:
  - entry array of {valid, done, id[7:0], kind, dest_logic, data, miss, new_pc};
  - head_id and tail_id, both 8-bit; slot index = id mod DEPTH;
  - count.
- Reset (sync, high): all valid/done = 0, head_id = tail_id = 0, count = 0.
  - Outputs after reset: alloc_id = 0, alloc_reject = 0, commit_en = 0, flush = 0, flush_pc = 0, result_reject = 0.
  - Reset mid-operation discards all entries; in-flight results then see result_reject.
- Allocation:
  - alloc_reject = (count == DEPTH) | flush.
  - alloc_id = tail_id (combinational).
  - On accept, at the edge: slot[tail] is set valid, not done, id = tail_id; tail_id wraps mod 256.
  - A same-cycle retirement does NOT free space for that cycle's allocation.
- Result accept:
  - Match = slot[result id].valid & !done & stored id == msg.commit_id.
  - result_reject = result_en & (!match | flush), combinational.
  - On accept: store kind plus payload, set done; visible at the head no earlier than the next cycle (one-cycle latency).
- Retirement, evaluated each cycle on the head slot:
  - Head not valid or not done: nothing retires.
  - Head is wb: commit_en = 1, commit_msg = {dest_logic, data}. The entry retires at the edge only if !commit_reject. commit_msg stays stable while rejected.
  - Head is a branch with miss = 0: retires silently at the edge; commit_en = 0.
  - Head is a branch with miss = 1: flush = 1, flush_pc = new_pc, combinational in the same cycle. At the edge all entries are cleared, head_id := tail_id, count := 0.
- Id reuse after flush:
  - Ids of squashed entries are never reused, so late results for them mismatch and are rejected.
  - System requirement: no result outstanding for more than 256 allocations.
- Pointers and count:
  - head_id increments by 1 per retire, mod 256.
  - count += alloc_accept − retire; on flush it becomes 0 regardless of any allocation that cycle.
- Simultaneous events:
  - A result for slot X and retirement of a different slot Y in the same cycle are independent.
  - A result written to the head slot does not commit in the cycle it arrives.
- Throughput: at most one allocation, one result, and one retirement per cycle.

Decomposition:
- Shared bus header (existing): `Result`, `CommitInfo`, `Message`.
- Shared package: constant COMMIT_DEPTH, plus an internal CommitSlot struct type.
- No sub-module required. Optionally split the storage array into `commit_slot_array`, with one write port for allocation, one for results, and an async read of the head slot.

Test Plan:
- Reset, then idle → alloc_id = 0, count = 0, commit_en = 0, flush = 0, result_reject = 0.
- Allocate ids 0,1,2; deliver wb results in order 2,0,1 (dest 5/6/7, data 0xA/0xB/0xC) → commits dest 5,6,7 in consecutive cycles, data 0xA,0xB,0xC; count returns to 0.
- Head wb done, commit_reject = 1 for 3 cycles → commit_en = 1 and commit_msg unchanged for 3 cycles; retires on the cycle reject drops; head_id advances by 1.
- Allocate 16 → alloc_reject = 1, count = 16.
  - Retire one with alloc_en high in the same cycle → allocation refused.
  - Next cycle → accepted with alloc_id = 16.
- Id 0 branch miss (new_pc 0x0040); ids 1 and 2 pending.
  - Result for id 0 arrives → next cycle flush = 1 and flush_pc = 0x0040 for exactly one cycle, then count = 0.
  - Late result for id 1 → result_reject = 1 and no commit follows.
  - Next allocation → alloc_id = 3.
- Results for never-allocated id 9 and a duplicate for an already-done id → result_reject = 1 each, state unchanged; also cover a branch with miss = 0 retiring with commit_en = 0 throughout.

Source files
------------

// File: rtl/commit_buffer_pkg.sv
// ============================================================================
// Module : commit_buffer_pkg
// Brief  : Result/CommitInfo bus types and the internal commit slot layout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package commit_buffer_pkg;

    localparam int COMMIT_DEPTH = 16;

    typedef enum logic {
        KIND_WB     = 1'b0,
        KIND_BRANCH = 1'b1
    } result_kind_e;

    // Execution-unit result packet carried on the Message channel
    typedef struct packed {
        logic [7:0]   commit_id;
        result_kind_e kind;
        logic [4:0]   dest_logic;
        logic [31:0]  data;
        logic         miss;
        logic [15:0]  new_pc;
    } Result;

    typedef struct packed {
        logic [4:0]  dest_logic;
        logic [31:0] data;
    } CommitInfo;

    typedef struct packed {
        logic         valid;
        logic         done;
        logic [7:0]   id;
        result_kind_e kind;
        logic [4:0]   dest_logic;
        logic [31:0]  data;
        logic         miss;
        logic [15:0]  new_pc;
    } CommitSlot;

endpackage

`default_nettype wire

// File: rtl/commit_buffer.sv
// ============================================================================
// Module : commit_buffer
// Brief  : In-order retirement buffer; accepts out-of-order results, retires
//          in allocation order, flushes on a mispredicted branch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_buffer
    import commit_buffer_pkg::*;
#(
    parameter int DEPTH = COMMIT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_en,
    output logic                     alloc_reject,
    output logic [7:0]               alloc_id,
    input  logic                     result_en,
    input  Result                    result_msg,
    output logic                     result_reject,
    output logic                     commit_en,
    output CommitInfo                commit_msg,
    input  logic                     commit_reject,
    output logic                     flush,
    output logic [15:0]              flush_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);

    CommitSlot          r_slots [DEPTH];
    logic [7:0]         r_head_id;
    logic [7:0]         r_tail_id;
    logic [IDX_W:0]     r_count;

    logic [IDX_W-1:0]   w_head_idx;
    logic [IDX_W-1:0]   w_tail_idx;
    logic [IDX_W-1:0]   w_res_idx;
    CommitSlot          w_head;
    CommitSlot          w_res_slot;
    logic               w_head_ready;
    logic               w_match;
    logic               w_alloc;
    logic               w_res_acc;
    logic               w_retire;

    assign w_head_idx   = r_head_id[IDX_W-1:0];
    assign w_tail_idx   = r_tail_id[IDX_W-1:0];
    assign w_res_idx    = result_msg.commit_id[IDX_W-1:0];
    assign w_head       = r_slots[w_head_idx];
    assign w_res_slot   = r_slots[w_res_idx];
    assign w_head_ready = w_head.valid & w_head.done;

    assign commit_en  = w_head_ready & (w_head.kind == KIND_WB);
    assign commit_msg = commit_en ? CommitInfo'({w_head.dest_logic, w_head.data}) : '0;
    assign flush      = w_head_ready & (w_head.kind == KIND_BRANCH) & w_head.miss;
    assign flush_pc   = flush ? w_head.new_pc : 16'h0000;

    // A wb retires only when downstream takes it; a correct branch retires silently
    assign w_retire = w_head_ready & ((commit_en & ~commit_reject) |
                      ((w_head.kind == KIND_BRANCH) & ~w_head.miss));

    // Full check uses the registered count, so a same-cycle retire frees nothing
    assign alloc_reject = (r_count == (IDX_W+1)'(DEPTH)) | flush;
    assign alloc_id     = r_tail_id;
    assign w_alloc      = alloc_en & ~alloc_reject;

    // Stored id check rejects late results for squashed or recycled slots
    assign w_match       = w_res_slot.valid & ~w_res_slot.done &
                           (w_res_slot.id == result_msg.commit_id);
    assign result_reject = result_en & (~w_match | flush);
    assign w_res_acc     = result_en & w_match & ~flush;

    assign count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
            r_head_id <= 8'd0;
            r_tail_id <= 8'd0;
            r_count   <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i].valid <= 1'b0;
                r_slots[i].done  <= 1'b0;
            end
            r_head_id <= r_tail_id;
            r_count   <= '0;
        end else begin
            if (w_retire) begin
                r_slots[w_head_idx].valid <= 1'b0;
                r_slots[w_head_idx].done  <= 1'b0;
                r_head_id                 <= r_head_id + 8'd1;
            end
            if (w_alloc) begin
                r_slots[w_tail_idx].valid <= 1'b1;
                r_slots[w_tail_idx].done  <= 1'b0;
                r_slots[w_tail_idx].id    <= r_tail_id;
                r_tail_id                 <= r_tail_id + 8'd1;
            end
            if (w_res_acc) begin
                r_slots[w_res_idx].done       <= 1'b1;
                r_slots[w_res_idx].kind       <= result_msg.kind;
                r_slots[w_res_idx].dest_logic <= result_msg.dest_logic;
                r_slots[w_res_idx].data       <= result_msg.data;
                r_slots[w_res_idx].miss       <= result_msg.miss;
                r_slots[w_res_idx].new_pc     <= result_msg.new_pc;
            end
            r_count <= r_count + {{IDX_W{1'b0}}, w_alloc} - {{IDX_W{1'b0}}, w_retire};
        end
    end

endmodule

`default_nettype wire
